// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle core control path: state encodings,
// RV32I opcode constants, datapath select encodings and opcode classification.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM    = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_ALUWB  = 4'd5,
    ST_HALT   = 4'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_JALR = 3'd6,
    CLS_ILL  = 3'd7
  } instr_cls_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_ALU  = 2'd1;
  localparam logic [1:0] PC_SRC_JALR = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  // Map a 7-bit opcode onto the instruction class the FSM sequences on.
  function automatic instr_cls_e decode_opcode(input logic [6:0] op);
    case (op)
      OP_R:    return CLS_R;
      OP_I:    return CLS_I;
      OP_LW:   return CLS_LW;
      OP_SW:   return CLS_SW;
      OP_BR:   return CLS_BR;
      OP_JAL:  return CLS_JAL;
      OP_JALR: return CLS_JALR;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Memory wait counter. Counts cycles a request is pending without mem_ready and
// flags a timeout on the TIMEOUT-th such cycle. A ready in that same cycle wins.
module ctrl_mem_timer #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt;

  // Counter restarts whenever no request is pending or the memory answers, so
  // each new FETCH/MEM request begins counting from zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n || !req || ready) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // Timeout fires on the wait cycle that brings the count up to TIMEOUT.
  assign timeout = req && !ready && (cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I-subset core. Sequences
// fetch/decode/execute/memory/writeback, drives every datapath select and
// enable, and halts on an illegal opcode or a memory timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state_o,
  output logic       halt,
  output logic       err
);

  state_e     state;
  instr_cls_e cls;
  logic       timeout;

  ctrl_mem_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // State register, latched instruction class and sticky halt/err flags.
  // The class is captured in DECODE so EXEC/MEM never depend on the IR again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      cls   <= CLS_ILL;
      halt  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (timeout) begin
            state <= ST_HALT;
            err   <= 1'b1;
          end else if (mem_ready) begin
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cls <= decode_opcode(opcode);
          if (decode_opcode(opcode) == CLS_ILL) begin
            state <= ST_HALT;
            halt  <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_R, CLS_I:               state <= ST_ALUWB;
            CLS_LW, CLS_SW:             state <= ST_MEM;
            CLS_BR, CLS_JAL, CLS_JALR:  state <= ST_FETCH;
            default:                    state <= ST_HALT;
          endcase
        end
        ST_MEM: begin
          if (timeout) begin
            state <= ST_HALT;
            err   <= 1'b1;
          end else if (mem_ready) begin
            state <= (cls == CLS_SW) ? ST_FETCH : ST_MEMWB;
          end
        end
        ST_MEMWB, ST_ALUWB: state <= ST_FETCH;
        default:            state <= ST_HALT;
      endcase
    end
  end

  // Control outputs decoded from the current state; everything is forced low
  // while reset is held so an outstanding memory request is dropped at once.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PC4;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_REG;
    alu_op    = ALU_ADD;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
        end
        ST_EXEC: begin
          case (cls)
            CLS_R: begin
              alu_src_a = SRC_A_REG;
              alu_op    = ALU_FUNCT;
            end
            CLS_I: begin
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_IMM;
              alu_op    = ALU_FUNCT;
            end
            CLS_LW, CLS_SW: begin
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_IMM;
            end
            CLS_BR: begin
              alu_src_a = SRC_A_REG;
              alu_op    = ALU_BRANCH;
              pc_write  = br_taken;
              pc_src    = PC_SRC_ALU;
            end
            CLS_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_ALU;
              reg_write = 1'b1;
              wb_sel    = WB_PC;
            end
            CLS_JALR: begin
              // Target is built from the latched A register, so rd == rs1 is safe.
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_IMM;
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JALR;
              reg_write = 1'b1;
              wb_sel    = WB_PC;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (cls == CLS_SW);
        end
        ST_MEMWB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        ST_ALUWB: begin
          reg_write = 1'b1;
          wb_sel    = WB_ALUOUT;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each cycle the expected control
// vector is pushed to a scoreboard queue as stimulus is driven, then popped and
// compared against the sampled DUT outputs mid-cycle.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       halt;
    logic       err;
  } ctl_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL} kind_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, halt, err;
  logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  ctl_t sb_q[$];

  multicycle_ctrl #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .state_o   (state_o),
    .halt      (halt),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected control vectors, written straight from the state/output table.
  function automatic ctl_t z(input logic [3:0] st, input logic h, input logic e);
    ctl_t c = '0;
    c.state = st;
    c.halt  = h;
    c.err   = e;
    return c;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = z(ST_FETCH, 1'b0, 1'b0);
    c.mem_req  = 1'b1;
    c.ir_write = rdy;
    c.pc_write = rdy;
    return c;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t c = z(ST_DECODE, 1'b0, 1'b0);
    c.alu_src_a = 2'd2;
    c.alu_src_b = 2'd1;
    return c;
  endfunction

  function automatic ctl_t e_exec(input kind_e k, input logic br);
    ctl_t c = z(ST_EXEC, 1'b0, 1'b0);
    case (k)
      K_R:  begin c.alu_src_a = 2'd1; c.alu_op = 2'd2; end
      K_I:  begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; c.alu_op = 2'd2; end
      K_LW, K_SW: begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; end
      K_BR: begin
        c.alu_src_a = 2'd1; c.alu_op = 2'd1; c.pc_write = br; c.pc_src = 2'd1;
      end
      K_JAL: begin
        c.pc_write = 1'b1; c.pc_src = 2'd1; c.reg_write = 1'b1; c.wb_sel = 2'd2;
      end
      K_JALR: begin
        c.alu_src_a = 2'd1; c.alu_src_b = 2'd1;
        c.pc_write = 1'b1; c.pc_src = 2'd2; c.reg_write = 1'b1; c.wb_sel = 2'd2;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t e_mem(input logic we);
    ctl_t c = z(ST_MEM, 1'b0, 1'b0);
    c.mem_req = 1'b1;
    c.mem_sel = 1'b1;
    c.mem_we  = we;
    return c;
  endfunction

  function automatic ctl_t e_wb(input logic [3:0] st, input logic [1:0] sel);
    ctl_t c = z(st, 1'b0, 1'b0);
    c.reg_write = 1'b1;
    c.wb_sel    = sel;
    return c;
  endfunction

  function automatic kind_e kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic ctl_t sample();
    return '{mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_src_a, alu_src_b, alu_op, state_o, halt, err};
  endfunction

  // One clock cycle: drive inputs after the falling edge, queue the expectation,
  // then sample the combinational outputs 1 ns later and score them.
  task automatic step(input logic rn, input logic rdy, input logic br,
                      input ctl_t exp, input string tag);
    ctl_t e;
    @(negedge clk);
    rst_n     = rn;
    mem_ready = rdy;
    br_taken  = br;
    sb_q.push_back(exp);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(tag, {10'd0, sample()}, {10'd0, e});
    end
  endtask

  // Two cycles of reset: the first still shows the pre-reset state (controls
  // already low), the second shows the cleared FETCH state.
  task automatic do_reset(input ctl_t pre, input string tag);
    step(1'b0, 1'b0, 1'b0, pre, {tag, ".rst_pre"});
    step(1'b0, 1'b0, 1'b0, z(ST_FETCH, 1'b0, 1'b0), {tag, ".rst_hold"});
  endtask

  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait,
                           input logic br, input int exp_cycles, input string name);
    kind_e k = kind_of(op);
    int    cyc = 0;
    opcode = op;
    for (int i = 0; i < fwait; i++) begin
      step(1'b1, 1'b0, 1'b0, e_fetch(1'b0), {name, ".fetch_wait"}); cyc++;
    end
    step(1'b1, 1'b1, 1'b0, e_fetch(1'b1), {name, ".fetch"}); cyc++;
    step(1'b1, 1'b0, 1'b0, e_decode(), {name, ".decode"}); cyc++;
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++)
        step(1'b1, 1'b1, 1'b0, z(ST_HALT, 1'b1, 1'b0), {name, ".halt"});
      return;
    end
    step(1'b1, 1'b0, br, e_exec(k, br), {name, ".exec"}); cyc++;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mwait; i++) begin
        step(1'b1, 1'b0, 1'b0, e_mem(k == K_SW), {name, ".mem_wait"}); cyc++;
      end
      step(1'b1, 1'b1, 1'b0, e_mem(k == K_SW), {name, ".mem"}); cyc++;
    end
    if (k == K_LW) begin
      step(1'b1, 1'b0, 1'b0, e_wb(ST_MEMWB, 2'd1), {name, ".memwb"}); cyc++;
    end
    if (k == K_R || k == K_I) begin
      step(1'b1, 1'b0, 1'b0, e_wb(ST_ALUWB, 2'd0), {name, ".aluwb"}); cyc++;
    end
    check({name, ".cycles"}, cyc, exp_cycles);
  endtask

  initial begin
    // Bring the state register out of X before the first scored cycle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b0, z(ST_FETCH, 1'b0, 1'b0), "reset");

    // Main instruction mix with zero-wait memory unless noted.
    run_instr(7'b0110011, 0, 0, 1'b0, 4, "add");      // add x3,x1,x2 (0x002081B3)
    run_instr(7'b0000011, 0, 3, 1'b0, 8, "lw_wait3");
    run_instr(7'b1100011, 0, 0, 1'b1, 3, "beq_taken");
    run_instr(7'b1100011, 0, 0, 1'b0, 3, "beq_not");
    run_instr(7'b1100111, 0, 0, 1'b0, 3, "jalr");     // jalr x1,0(x1)
    run_instr(7'b1101111, 0, 0, 1'b0, 3, "jal");
    run_instr(7'b0100011, 0, 0, 1'b0, 4, "sw");
    run_instr(7'b0010011, 0, 0, 1'b0, 4, "addi");
    run_instr(7'b0000011, 0, 0, 1'b0, 5, "lw");
    run_instr(7'b0110011, 2, 0, 1'b0, 6, "add_fwait2");

    // Illegal opcode halts after DECODE and stays quiet until reset.
    run_instr(7'b1111111, 0, 0, 1'b0, 0, "illegal");
    do_reset(z(ST_HALT, 1'b1, 1'b0), "illegal");

    // Fetch timeout: four cycles with no ready, then HALT with err.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, e_fetch(1'b0), "fto.wait");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, z(ST_HALT, 1'b0, 1'b1), "fto.halt");
    do_reset(z(ST_HALT, 1'b0, 1'b1), "fto");

    // Ready on the 4th fetch cycle completes normally.
    run_instr(7'b0110011, 3, 0, 1'b0, 7, "add_ready4");

    // Same-cycle ready in MEM at the boundary, then a MEM timeout.
    run_instr(7'b0100011, 0, 3, 1'b0, 7, "sw_ready4");
    opcode = 7'b0000011;
    step(1'b1, 1'b1, 1'b0, e_fetch(1'b1), "mto.fetch");
    step(1'b1, 1'b0, 1'b0, e_decode(), "mto.decode");
    step(1'b1, 1'b0, 1'b0, e_exec(K_LW, 1'b0), "mto.exec");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, e_mem(1'b0), "mto.wait");
    step(1'b1, 1'b0, 1'b0, z(ST_HALT, 1'b0, 1'b1), "mto.halt");
    do_reset(z(ST_HALT, 1'b0, 1'b1), "mto");

    // Reset in the middle of a MEM wait drops the request immediately.
    step(1'b1, 1'b1, 1'b0, e_fetch(1'b1), "rmem.fetch");
    step(1'b1, 1'b0, 1'b0, e_decode(), "rmem.decode");
    step(1'b1, 1'b0, 1'b0, e_exec(K_LW, 1'b0), "rmem.exec");
    step(1'b1, 1'b0, 1'b0, e_mem(1'b0), "rmem.wait");
    do_reset(z(ST_MEM, 1'b0, 1'b0), "rmem");
    step(1'b1, 1'b0, 1'b0, e_fetch(1'b0), "rmem.after");
    run_instr(7'b0110011, 0, 0, 1'b0, 4, "add_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
